// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit, producer side of the IF/ID register.
// Issues PC-ordered requests to the instruction ROM over req/gnt/rvalid,
// keeps returned words in an in-order fetch buffer and presents the head
// entry to if_id. Handles EX jump redirects and ctrl hold requests.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   jump_en_i, jump_addr_i    redirect request and target (word aligned)
//   hold_en_i                 bit0 stalls PC/requests, bit1 loads IF/ID
//   rom_req_o, rom_addr_o     ROM request channel
//   rom_gnt_i                 ROM accepts the request this cycle
//   rom_rvalid_i, rom_rdata_i in-order ROM responses
//   inst_o, instaddr_o        instruction and address to if_id
//   empty_o                   buffer head holds no instruction
// Optional macro IFU_RVALID_BYPASS_EN forwards a response that fills the
// head entry straight to inst_o in the same cycle.

`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module ifu_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic [4:0]  hold_en_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_gnt_i,
    input  logic        rom_rvalid_i,
    input  logic [31:0] rom_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] instaddr_o,
    output logic        empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    // Repeated jumps can stack stale responses beyond DEPTH.
    localparam int unsigned DW = AW + 4;

    logic [31:0]      fetch_pc;
    logic [DEPTH-1:0] reserved;
    logic [DEPTH-1:0] filled;
    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    fl_ptr;
    logic [CW-1:0]    res_cnt;
    logic [CW-1:0]    unf_cnt;
    logic [DW-1:0]    discard_cnt;

    logic        full;
    logic        acc;
    logic        rsp_drop;
    logic        rsp_fill;
    logic        rsp_any;
    logic        head_hit;
    logic        head_valid;
    logic        pop;
    logic [31:0] head_data;
    logic        unused_bits;

    assign unused_bits = ^{hold_en_i[4:2], jump_addr_i[1:0]};

    assign full       = (res_cnt == CW'(DEPTH));
    assign rom_req_o  = rstn & ~jump_en_i & ~hold_en_i[0] & ~full;
    assign rom_addr_o = fetch_pc;
    assign acc        = rom_req_o & rom_gnt_i;

    assign rsp_drop = rom_rvalid_i & (discard_cnt != '0);
    assign rsp_fill = rom_rvalid_i & (discard_cnt == '0)
                    & (unf_cnt != '0);
    assign rsp_any  = rsp_drop | rsp_fill;

`ifdef IFU_RVALID_BYPASS_EN
    // Fill pointer equals rd_ptr whenever the head is reserved-unfilled.
    assign head_hit  = rsp_fill & reserved[rd_ptr] & ~filled[rd_ptr];
    assign head_data = filled[rd_ptr] ? data_q[rd_ptr] : rom_rdata_i;
`else
    assign head_hit  = 1'b0;
    assign head_data = data_q[rd_ptr];
`endif

    assign head_valid = filled[rd_ptr] | head_hit;
    assign pop        = hold_en_i[1] & head_valid & ~jump_en_i;
    assign empty_o    = ~head_valid;
    assign inst_o     = (head_valid & ~jump_en_i) ? head_data
                                                  : `INST_NOP;
    assign instaddr_o = reserved[rd_ptr] ? addr_q[rd_ptr] : fetch_pc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc    <= RESET_ADDR;
            reserved    <= '0;
            filled      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fl_ptr      <= '0;
            res_cnt     <= '0;
            unf_cnt     <= '0;
            discard_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (jump_en_i) begin
            // Outstanding unfilled slots become stale responses; one
            // arriving now is consumed against that total.
            fetch_pc    <= {jump_addr_i[31:2], 2'b00};
            reserved    <= '0;
            filled      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fl_ptr      <= '0;
            res_cnt     <= '0;
            unf_cnt     <= '0;
            discard_cnt <= discard_cnt + DW'(unf_cnt) - DW'(rsp_any);
        end else begin
            if (acc) begin
                reserved[wr_ptr] <= 1'b1;
                addr_q[wr_ptr]   <= fetch_pc;
                fetch_pc         <= fetch_pc + 32'd4;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (rsp_fill) begin
                filled[fl_ptr] <= 1'b1;
                data_q[fl_ptr] <= rom_rdata_i;
                fl_ptr         <= fl_ptr + 1'b1;
            end
            // Placed last so a bypassed fill of the head is freed.
            if (pop) begin
                reserved[rd_ptr] <= 1'b0;
                filled[rd_ptr]   <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            if (rsp_drop) begin
                discard_cnt <= discard_cnt - 1'b1;
            end
            res_cnt <= res_cnt + CW'(acc) - CW'(pop);
            unf_cnt <= unf_cnt + CW'(acc) - CW'(rsp_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(rom_rvalid_i && unf_cnt == '0
                      && discard_cnt == '0))
            else $error("ifu_fetch: rom_rvalid_i with nothing pending");
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed self-checking bench for ifu_fetch.
// Behavioural ROM with programmable latency answers data = ~address.

module tb_ifu_fetch;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [4:0]  H_NONE = 5'b00000;
    localparam logic [4:0]  H_PC   = 5'b00001;
    localparam logic [4:0]  H_LD   = 5'b00010;

    logic        clk;
    logic        rstn;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic [4:0]  hold_en_i;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i;
    logic        rom_rvalid_i;
    logic [31:0] rom_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] instaddr_o;
    logic        empty_o;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t pend[$];
    int   cyc;
    int   lat;
    int   errors;
    int   checks;

    ifu_fetch dut (
        .clk          (clk),
        .rstn         (rstn),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .hold_en_i    (hold_en_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_gnt_i    (rom_gnt_i),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .inst_o       (inst_o),
        .instaddr_o   (instaddr_o),
        .empty_o      (empty_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rom_drive();
        req_t r;
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = '0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            rom_rvalid_i = 1'b1;
            rom_rdata_i  = ~r.addr;
        end
    endtask

    // One clock cycle: drive at negedge, check once settled, advance.
    task automatic step(input logic [4:0] hold, input logic jmp,
                        input logic [31:0] jaddr, input string tag,
                        input logic ereq, input logic [31:0] eaddr,
                        input logic [31:0] einst,
                        input logic [31:0] eiaddr);
        req_t r;
        hold_en_i   = hold;
        jump_en_i   = jmp;
        jump_addr_i = jaddr;
        rom_drive();
        #1;
        chk({tag, ".req"}, {31'd0, rom_req_o}, {31'd0, ereq});
        chk({tag, ".addr"}, rom_addr_o, eaddr);
        chk({tag, ".inst"}, inst_o, einst);
        chk({tag, ".iaddr"}, instaddr_o, eiaddr);
        // No ROM word equals NOP, so NOP on inst_o means an empty head.
        chk({tag, ".empty"}, {31'd0, empty_o},
            {31'd0, einst == NOP});
        if (rom_req_o && rom_gnt_i) begin
            r.addr = rom_addr_o;
            r.due  = cyc + lat;
            pend.push_back(r);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int new_lat);
        rstn         = 1'b0;
        jump_en_i    = 1'b0;
        jump_addr_i  = '0;
        hold_en_i    = H_LD;
        rom_gnt_i    = 1'b1;
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = '0;
        pend.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cyc  = 0;
        lat  = new_lat;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        lat    = 1;
        rstn   = 1'b0;
        jump_en_i    = 1'b0;
        jump_addr_i  = '0;
        hold_en_i    = H_LD;
        rom_gnt_i    = 1'b1;
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = '0;
        #1;
        chk("rst.req", {31'd0, rom_req_o}, 32'd0);
        chk("rst.inst", inst_o, NOP);
        chk("rst.iaddr", instaddr_o, 32'h0);
        chk("rst.empty", {31'd0, empty_o}, 32'd1);

        // Streaming, 1-cycle ROM, continuous IF/ID load.
        do_reset(1);
        step(H_LD, 0, 0, "s0", 1, 32'h0,  NOP,   32'h0);
        step(H_LD, 0, 0, "s1", 1, 32'h4,  NOP,   32'h0);
        step(H_LD, 0, 0, "s2", 0, 32'h8,  ~32'h0, 32'h0);
        step(H_LD, 0, 0, "s3", 1, 32'h8,  ~32'h4, 32'h4);
        step(H_LD, 0, 0, "s4", 1, 32'hc,  NOP,   32'h8);
        step(H_LD, 0, 0, "s5", 0, 32'h10, ~32'h8, 32'h8);
        step(H_LD, 0, 0, "s6", 1, 32'h10, ~32'hc, 32'hc);

        // 3-cycle ROM: throttling at two reserved, NOP bubbles.
        do_reset(3);
        step(H_LD, 0, 0, "l0", 1, 32'h0,  NOP,    32'h0);
        step(H_LD, 0, 0, "l1", 1, 32'h4,  NOP,    32'h0);
        step(H_LD, 0, 0, "l2", 0, 32'h8,  NOP,    32'h0);
        step(H_LD, 0, 0, "l3", 0, 32'h8,  NOP,    32'h0);
        step(H_LD, 0, 0, "l4", 0, 32'h8,  ~32'h0, 32'h0);
        step(H_LD, 0, 0, "l5", 1, 32'h8,  ~32'h4, 32'h4);
        step(H_LD, 0, 0, "l6", 1, 32'hc,  NOP,    32'h8);

        // Jump with two requests in flight; stale data must vanish.
        step(H_LD, 1, 32'h103, "j7", 0, 32'h10, NOP, 32'h8);
        step(H_LD, 0, 0, "j8",  1, 32'h100, NOP, 32'h100);
        step(H_LD, 0, 0, "j9",  1, 32'h104, NOP, 32'h100);
        step(H_LD, 0, 0, "j10", 0, 32'h108, NOP, 32'h100);
        step(H_LD, 0, 0, "j11", 0, 32'h108, NOP, 32'h100);
        step(H_LD, 0, 0, "j12", 0, 32'h108, ~32'h100, 32'h100);

        // PC hold with two in flight, then stall while full.
        do_reset(3);
        step(H_NONE, 0, 0, "h0", 1, 32'h0, NOP,    32'h0);
        step(H_NONE, 0, 0, "h1", 1, 32'h4, NOP,    32'h0);
        step(H_PC,   0, 0, "h2", 0, 32'h8, NOP,    32'h0);
        step(H_PC,   0, 0, "h3", 0, 32'h8, NOP,    32'h0);
        step(H_PC,   0, 0, "h4", 0, 32'h8, ~32'h0, 32'h0);
        step(H_PC,   0, 0, "h5", 0, 32'h8, ~32'h0, 32'h0);
        step(H_NONE, 0, 0, "h6", 0, 32'h8, ~32'h0, 32'h0);
        step(H_LD,   0, 0, "h7", 0, 32'h8, ~32'h0, 32'h0);
        step(H_LD,   0, 0, "h8", 1, 32'h8, ~32'h4, 32'h4);
        step(H_LD,   0, 0, "h9", 1, 32'hc, NOP,    32'h8);

        // Asynchronous reset in the middle of a cycle.
        hold_en_i = H_LD;
        rom_drive();
        #1;
        rstn = 1'b0;
        #1;
        chk("ar.req", {31'd0, rom_req_o}, 32'd0);
        chk("ar.addr", rom_addr_o, 32'h0);
        chk("ar.inst", inst_o, NOP);
        chk("ar.iaddr", instaddr_o, 32'h0);
        chk("ar.empty", {31'd0, empty_o}, 32'd1);
        do_reset(1);
        step(H_LD, 0, 0, "r0", 1, 32'h0, NOP,    32'h0);
        step(H_LD, 0, 0, "r1", 1, 32'h4, NOP,    32'h0);
        step(H_LD, 0, 0, "r2", 0, 32'h8, ~32'h0, 32'h0);

        // Jump in the same cycle a response arrives.
        do_reset(2);
        step(H_LD, 0, 0, "q0", 1, 32'h0, NOP, 32'h0);
        step(H_LD, 0, 0, "q1", 1, 32'h4, NOP, 32'h0);
        step(H_LD, 1, 32'h43, "q2", 0, 32'h8, NOP, 32'h0);
        step(H_LD, 0, 0, "q3", 1, 32'h40, NOP, 32'h40);
        step(H_LD, 0, 0, "q4", 1, 32'h44, NOP, 32'h40);
        step(H_LD, 0, 0, "q5", 0, 32'h48, NOP, 32'h40);
        step(H_LD, 0, 0, "q6", 0, 32'h48, ~32'h40, 32'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
